// File: rtl/placar_multitime.sv
// placar_multitime: registered multi-team scoreboard with button sync, saturating score updates, buzzer and scanned 7-segment display (optional leading-zero blanking via BLANK_ZEROS_EN)
module placar_multitime #(
  parameter int N_TIMES = 2,
  parameter int PONTOS_W = 8,
  parameter int PONTOS_MAX = 199,
  parameter int DIGITOS = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BUZZER_CICLOS = 50000,
  localparam int SEL_W = (N_TIMES > 2) ? $clog2(N_TIMES) : 1
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [2:0]                    cBotoes,
  input  logic                          chaveNP,
  input  logic [SEL_W-1:0]              selTime,
  input  logic                          zerar,
  output logic [N_TIMES*PONTOS_W-1:0]   pontos,
  output logic [6:0]                    display,
  output logic [N_TIMES*DIGITOS-1:0]    escolhaDisplay,
  output logic                          buzzer,
  output logic                          led
);
  localparam int NDIG = N_TIMES * DIGITOS;
  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BUZZER_CICLOS + 1);
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_TIMES);
  localparam logic [PONTOS_W+1:0] MAX_W = (PONTOS_W + 2)'(PONTOS_MAX);
  localparam logic [PONTOS_W-1:0] MAX_P = PONTOS_W'(PONTOS_MAX);
  localparam logic [BW-1:0] BUZ_LD = BW'(BUZZER_CICLOS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [3:0] s1, s2, s3, pul;
  logic [PONTOS_W-1:0] score [N_TIMES];
  logic [1:0] inc;
  logic upd, sel_ok, sat;
  logic [PONTOS_W-1:0] cur;
  logic [PONTOS_W+1:0] sum;
  logic [BW-1:0] buz_cnt;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic wrap;
  logic [DIGITOS*4-1:0] bcd [N_TIMES];
  logic [3:0] dig;
  logic [6:0] seg_n;
`ifdef BLANK_ZEROS_EN
  logic blank;
`endif

  function automatic logic [DIGITOS*4-1:0] dabble(input logic [PONTOS_W-1:0] v);
    logic [DIGITOS*4-1:0] b;
    b = '0;
    for (int i = PONTOS_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITOS; d++)
        if (b[d*4+:4] > 4'd4) b[d*4+:4] = b[d*4+:4] + 4'd3;
      b = {b[DIGITOS*4-2:0], v[i]};
    end
    return b;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  for (genvar t = 0; t < N_TIMES; t++) begin : g_out
    assign pontos[t*PONTOS_W +: PONTOS_W] = score[t];
  end

  assign buzzer = buz_cnt != '0;

  // Edge pulses (bit3 = zerar), increment priority and add/sub arithmetic for the selected team
  always_comb begin
    pul = s2 & ~s3;
    inc = pul[2] ? 2'd3 : pul[1] ? 2'd2 : {1'b0, pul[0]};
    upd = |pul;
    sel_ok = {1'b0, selTime} < N_LIM;
    cur = sel_ok ? score[selTime] : '0;
    sum = {2'b00, cur} + (PONTOS_W + 2)'(inc);
    sat = sum > MAX_W;
  end

  // Two-flop synchroniser plus a previous-value flop for edge detection
  always_ff @(posedge clock) begin
    if (!resetN) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {zerar, cBotoes};
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Score update: invalid team flags error, clear beats buttons, add saturates, sub refuses underflow
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int t = 0; t < N_TIMES; t++) score[t] <= '0;
      led <= 1'b0;
    end else if (upd) begin
      if (!sel_ok) led <= 1'b1;
      else if (pul[3]) begin
        score[selTime] <= '0;
        led <= 1'b0;
      end else if (!chaveNP) begin
        score[selTime] <= sat ? MAX_P : sum[PONTOS_W-1:0];
        led <= 1'b0;
      end else if (PONTOS_W'(inc) > cur) led <= 1'b1;
      else begin
        score[selTime] <= cur - PONTOS_W'(inc);
        led <= 1'b0;
      end
    end
  end

  // Buzzer countdown, reloaded on every saturating add
  always_ff @(posedge clock) begin
    if (!resetN) buz_cnt <= '0;
    else if (upd && sel_ok && !pul[3] && !chaveNP && sat) buz_cnt <= BUZ_LD;
    else buz_cnt <= (buz_cnt != '0) ? buz_cnt - 1'b1 : '0;
  end

  // BCD conversion of every live score
  always_comb begin
    for (int t = 0; t < N_TIMES; t++) bcd[t] = dabble(score[t]);
  end

  // Scan sequencing and selection of the digit that will be lit after the next edge
  always_comb begin
    wrap = cnt == CNT_LAST;
    cnt_n = wrap ? '0 : cnt + 1'b1;
    idx_n = !wrap ? idx : (idx == IDX_LAST) ? '0 : idx + 1'b1;
    dig = '0;
`ifdef BLANK_ZEROS_EN
    blank = 1'b0;
`endif
    for (int t = 0; t < N_TIMES; t++)
      for (int d = 0; d < DIGITOS; d++)
        if (idx_n == IW'(t * DIGITOS + d)) begin
          dig = bcd[t][d*4+:4];
`ifdef BLANK_ZEROS_EN
          blank = (d > 0) && ((bcd[t] >> (4 * d)) == '0);
`endif
        end
`ifdef BLANK_ZEROS_EN
    seg_n = blank ? 7'b1111111 : seg7(dig);
`else
    seg_n = seg7(dig);
`endif
  end

  // Registered scan outputs so segments and enables only move on clock edges
  always_ff @(posedge clock) begin
    if (!resetN) begin
      cnt <= '0;
      idx <= '0;
      escolhaDisplay <= ~NDIG'(1);
      display <= 7'b1000000;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      escolhaDisplay <= ~(NDIG'(1) << idx_n);
      display <= seg_n;
    end
  end
endmodule

// File: tb/tb_placar_multitime.sv
// tb_placar_multitime: randomized self-checking bench against a score/scan reference model
module tb_placar_multitime;
  localparam int NT = 3, PW = 8, PMAX = 199, DG = 3, SD = 4, BZ = 5, ND = NT * DG;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic [2:0] cBotoes = '0;
  logic chaveNP = 1'b0;
  logic [1:0] selTime = '0;
  logic zerar = 1'b0;
  logic [NT*PW-1:0] pontos;
  logic [6:0] display;
  logic [ND-1:0] escolhaDisplay;
  logic buzzer, led;

  int errors = 0, checks = 0, k = 0;
  int m [NT];
  logic mled = 1'b0;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  placar_multitime #(.N_TIMES(NT), .PONTOS_W(PW), .PONTOS_MAX(PMAX), .DIGITOS(DG),
                     .SCAN_DIV(SD), .BUZZER_CICLOS(BZ)) dut (
    .clock(clock), .resetN(resetN), .cBotoes(cBotoes), .chaveNP(chaveNP), .selTime(selTime),
    .zerar(zerar), .pontos(pontos), .display(display), .escolhaDisplay(escolhaDisplay),
    .buzzer(buzzer), .led(led));

  always #5 clock = ~clock;

  // edges since the last reset edge
  always @(posedge clock) k <= resetN ? k + 1 : 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NT*PW-1:0] flat();
    logic [NT*PW-1:0] f;
    for (int t = 0; t < NT; t++) f[t*PW+:PW] = PW'(m[t]);
    return f;
  endfunction

  task automatic press(input int s, input bit np, input logic [2:0] b, input bit z, input int hold);
    bit sat = 0;
    int hi = 0;
    int inc;
    @(negedge clock);
    selTime = 2'(s); chaveNP = np; cBotoes = b; zerar = z;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("pre", pontos, flat());
    @(posedge clock);
    if (z || b != 0) begin
      if (s >= NT) mled = 1;
      else if (z) begin m[s] = 0; mled = 0; end
      else begin
        inc = b[2] ? 3 : b[1] ? 2 : 1;
        if (!np) begin
          if (m[s] + inc > PMAX) begin m[s] = PMAX; sat = 1; end
          else m[s] += inc;
          mled = 0;
        end else if (inc > m[s]) mled = 1;
        else begin m[s] -= inc; mled = 0; end
      end
    end
    @(negedge clock);
    check("pontos", pontos, flat());
    check("led", led, mled);
    hi += int'(buzzer);
    repeat (6) begin
      @(negedge clock);
      hi += int'(buzzer);
    end
    check("buzlen", hi, sat ? BZ : 0);
    repeat (hold) @(negedge clock);
    cBotoes = '0; zerar = 0;
    repeat (3) @(negedge clock);
    check("held", pontos, flat());
  endtask

  task automatic scan(input int n);
    int idx, t, d, p, dig;
    logic [6:0] e;
    logic [ND-1:0] en;
    repeat (n) begin
      @(negedge clock);
      idx = (k / SD) % ND;
      t = idx / DG;
      d = idx % DG;
      p = 1;
      for (int j = 0; j < d; j++) p *= 10;
      dig = (m[t] / p) % 10;
      e = segs[dig];
`ifdef BLANK_ZEROS_EN
      if (d > 0 && m[t] / p == 0) e = 7'b1111111;
`endif
      en = ~(ND'(1) << idx);
      check("enable", escolhaDisplay, en);
      check("segment", display, e);
    end
  endtask

  initial begin
    logic [ND-1:0] en0;
    for (int t = 0; t < NT; t++) m[t] = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    en0 = ~ND'(1);
    check("rst_pontos", pontos, 0);
    check("rst_led", led, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_enable", escolhaDisplay, en0);
    check("rst_display", display, 7'b1000000);
    resetN = 1'b1;
    press(1, 0, 3'b100, 0, 100);
    repeat (66) press(0, 0, 3'b100, 0, 0);
    press(0, 0, 3'b100, 0, 0);
    press(0, 0, 3'b000, 1, 0);
    press(0, 0, 3'b001, 0, 0);
    press(0, 1, 3'b010, 0, 0);
    press(0, 0, 3'b001, 0, 0);
    press(0, 0, 3'b000, 1, 0);
    repeat (41) press(0, 0, 3'b100, 0, 0);
    press(1, 0, 3'b000, 1, 0);
    press(1, 0, 3'b100, 0, 0);
    press(1, 0, 3'b100, 0, 0);
    press(1, 0, 3'b001, 0, 0);
    scan(2 * ND * SD + 3);
    press(0, 0, 3'b101, 0, 0);
    press(0, 0, 3'b010, 1, 0);
    press(3, 0, 3'b001, 0, 0);
    repeat (120)
      press($urandom_range(0, 3), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2));
    scan(2 * ND * SD);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/placar_multitime.md
Name: placar_multitime

Overview:
Registered, parametrised successor to the combinational basketball scoreboard path.
- Holds scores for N_TIMES teams in registers.
- Converts raw point buttons into single-cycle events: synchroniser plus rising-edge detect.
- Adds or subtracts 1/2/3 points on the selected team, with saturation and error signalling.
- Time-multiplexes all BCD digits of all teams onto one 7-segment bus with a free-running scan counter.

Parameters:
- N_TIMES, 2: number of teams, ≥ 2.
- PONTOS_W, 8: score register width.
- PONTOS_MAX, 199: saturation ceiling. Must be < 2^PONTOS_W and < 10^DIGITOS.
- DIGITOS, 3: BCD digits displayed per team.
- SCAN_DIV, 1000: clock cycles each digit stays lit, ≥ 2.
- BUZZER_CICLOS, 50000: buzzer pulse length in cycles, ≥ 1.

Ports:
- clock, input, 1: system clock, rising edge.
- resetN, input, 1: synchronous active-low reset.
- cBotoes, input, 3: raw async buttons; bit0 = +1, bit1 = +2, bit2 = +3.
- chaveNP, input, 1: operation mode; 0 = add, 1 = subtract. Level, sampled on the update cycle.
- selTime, input, max(1,$clog2(N_TIMES)): selected team. Sampled on the update cycle.
- zerar, input, 1: raw async request to clear the selected team's score.
- pontos, output, N_TIMES*PONTOS_W: all scores flattened; team t in bits [t*PONTOS_W +: PONTOS_W].
- display, output, 7: active-low segments; bit0 = a ... bit6 = g.
- escolhaDisplay, output, N_TIMES*DIGITOS: active-low one-hot digit enable.
- buzzer, output, 1: high for BUZZER_CICLOS cycles after a saturating add.
- led, output, 1: sticky error flag.

Behaviour:
- Reset, resetN=0 at a rising edge:
  - all scores = 0, led = 0, buzzer = 0, buzzer counter = 0;
  - scan counter and digit index = 0; escolhaDisplay = all ones except bit0 = 0;
  - synchroniser/edge flops = 0.
  - Reset dominates every other input on that edge.
- Synchronisation:
  - cBotoes and zerar each pass through 2 flops, then a third "previous" flop; pulse = s2 & ~s3.
  - Input high before edge E0 produces an update at E2. pontos changes after E2.
  - A held input yields exactly one event; it must go low and high again to re-fire.
- Increment selection: on simultaneous button pulses the highest bit wins (bit2 = 3, else bit1 = 2, else bit0 = 1).
- Priority on an update cycle: zerar pulse > button pulse.
- Update rules, with selTime ≥ N_TIMES checked first:
  - selTime ≥ N_TIMES: no score change, led := 1.
  - zerar: selected score := 0, led := 0.
  - Add: if score + inc > PONTOS_MAX, score := PONTOS_MAX, buzzer counter := BUZZER_CICLOS, led := 0. Otherwise score += inc, led := 0. Computed at PONTOS_W+2 bits, so no wrap.
  - Subtract: if inc > score, no change, led := 1. Otherwise score -= inc, led := 0.
  - Unselected teams never change.
- Buzzer:
  - buzzer = (counter != 0); counter decrements each cycle to 0.
  - A new saturation while it is running reloads the counter to BUZZER_CICLOS.
- Display scan:
  - Counter counts 0..SCAN_DIV-1, then advances the digit index.
  - Index wraps from N_TIMES*DIGITOS-1 to 0.
  - Index i = t*DIGITOS + d: team t, digit d (d=0 = units).
  - escolhaDisplay[i] = 0, all other bits = 1.
  - display is a registered 7-segment decode of that BCD digit, updated on the same edge as escolhaDisplay.
  - BCD comes from a combinational double-dabble conversion of the live score.
- Scan continues unchanged through score updates. No glitch: display and escolhaDisplay change only on clock edges.

Optional Feature:
BLANK_ZEROS_EN
- Defined: a leading-zero digit (d > 0 and all digits ≥ d are zero) drives display = 7'b1111111 while its escolhaDisplay bit is still asserted. Units digit is never blanked.
- Undefined: all digits always shown, so 0 shows as "000".

Test Plan:
1. Drive resetN=0 for 2 edges, then release. -> pontos=0, led=0, buzzer=0, escolhaDisplay=...1110, display=7'b1000000 ("0").
2. selTime=1, chaveNP=0, cBotoes[2] high from E0 and held 100 cycles. -> team1 = 3 after E2, stays 3; team0 = 0.
3. Team0 = 198, press +3 with BUZZER_CICLOS=5. -> team0 = 199; buzzer high exactly 5 cycles; led=0.
4. Team0 = 1, chaveNP=1, press +2. -> team0 = 1, led=1. Then chaveNP=0, press +1. -> team0 = 2, led=0.
5. SCAN_DIV=4, team0 = 123, team1 = 7, feature off. -> digit sequence 3,2,1,7,0,0, each lit 4 cycles, then wraps to index 0.
6. cBotoes[0] and cBotoes[2] rise on the same edge. -> +3. Then zerar and cBotoes[1] pulse together. -> score 0. Then selTime=3 with N_TIMES=2, press +1. -> no change, led=1.
